// File: rtl/acc_exec_pkg.sv
// Shared types and default widths for the accumulator execute unit.
package acc_exec_pkg;

  localparam int DATA_W_DEF = 8;
  localparam int ADDR_W_DEF = 5;

  typedef enum logic [2:0] {
    OP_LDA  = 3'd0,
    OP_STA  = 3'd1,
    OP_ADD  = 3'd2,
    OP_SUB  = 3'd3,
    OP_AND  = 3'd4,
    OP_OR   = 3'd5,
    OP_XOR  = 3'd6,
    OP_XNOR = 3'd7
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MEM  = 2'd1,
    ST_EXEC = 2'd2,
    ST_DONE = 2'd3
  } state_e;

  function automatic logic is_store(input op_e op);
    return (op == OP_STA);
  endfunction

endpackage

// File: rtl/acc_exec_unit_alu.sv
// Combinational ALU: result and flags from op, accumulator (a) and memory operand (b).
module acc_alu
  import acc_exec_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF
) (
  input  op_e               i_op,
  input  logic [DATA_W-1:0] i_a,
  input  logic [DATA_W-1:0] i_b,
  output logic [DATA_W-1:0] o_result,
  output logic              o_carry,
  output logic              o_zero
);

  logic [DATA_W:0] w_sum;
  logic [DATA_W:0] w_diff;

  assign w_sum  = {1'b0, i_a} + {1'b0, i_b};
  // Top bit of the widened difference is the borrow; carry means no borrow.
  assign w_diff = {1'b0, i_a} - {1'b0, i_b};

  always_comb begin
    o_result = i_a;
    o_carry  = 1'b0;
    case (i_op)
      OP_LDA:  o_result = i_b;
      OP_ADD: begin
        o_result = w_sum[DATA_W-1:0];
        o_carry  = w_sum[DATA_W];
      end
      OP_SUB: begin
        o_result = w_diff[DATA_W-1:0];
        o_carry  = ~w_diff[DATA_W];
      end
      OP_AND:  o_result = i_a & i_b;
      OP_OR:   o_result = i_a | i_b;
      OP_XOR:  o_result = i_a ^ i_b;
      OP_XNOR: o_result = ~(i_a ^ i_b);
      default: o_result = i_a;
    endcase
  end

  assign o_zero = (o_result == '0);

endmodule

// File: rtl/acc_exec_unit.sv
// Accumulator execute unit: accepts one instruction, runs its memory transaction,
// then applies the ALU op and writes AC and flags.
//   state | meaning
//   IDLE  | ready for an instruction
//   MEM   | memory request outstanding, waiting for ack
//   EXEC  | ALU result registered into AC/flags
//   DONE  | one-cycle completion pulse
module acc_exec_unit
  import acc_exec_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              instr_valid,
  output logic              instr_ready,
  input  logic [2:0]        instr_op,
  input  logic [ADDR_W-1:0] instr_addr,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_ack,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [DATA_W-1:0] ac,
  output logic              zero,
  output logic              carry,
  output logic              done
);

  state_e            r_state;
  state_e            w_state_nxt;
  op_e               r_op;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_m;
  logic [DATA_W-1:0] r_ac;
  logic              r_zero;
  logic              r_carry;

  logic [DATA_W-1:0] w_alu_result;
  logic              w_alu_carry;
  logic              w_alu_zero;
  logic              w_accept;

  assign w_accept = (r_state == ST_IDLE) && instr_valid;

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: if (instr_valid) w_state_nxt = ST_MEM;
      ST_MEM: begin
        if (mem_ack) w_state_nxt = is_store(r_op) ? ST_DONE : ST_EXEC;
      end
      ST_EXEC: w_state_nxt = ST_DONE;
      ST_DONE: w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_op   <= OP_LDA;
      r_addr <= '0;
    end else if (w_accept) begin
      r_op   <= op_e'(instr_op);
      r_addr <= instr_addr;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_m <= '0;
    end else if ((r_state == ST_MEM) && mem_ack && !is_store(r_op)) begin
      r_m <= mem_rdata;
    end
  end

  acc_alu #(
    .DATA_W (DATA_W)
  ) u_alu (
    .i_op     (r_op),
    .i_a      (r_ac),
    .i_b      (r_m),
    .o_result (w_alu_result),
    .o_carry  (w_alu_carry),
    .o_zero   (w_alu_zero)
  );

  // STA never reaches EXEC, so AC and flags only move for read ops.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ac    <= '0;
      r_zero  <= 1'b1;
      r_carry <= 1'b0;
    end else if (r_state == ST_EXEC) begin
      r_ac    <= w_alu_result;
      r_zero  <= w_alu_zero;
      r_carry <= w_alu_carry;
    end
  end

  assign instr_ready = (r_state == ST_IDLE);
  assign mem_req     = (r_state == ST_MEM);
  assign mem_we      = (r_state == ST_MEM) && is_store(r_op);
  assign mem_addr    = r_addr;
  assign mem_wdata   = r_ac;
  assign done        = (r_state == ST_DONE);
  assign ac          = r_ac;
  assign zero        = r_zero;
  assign carry       = r_carry;

endmodule
